// File: rtl/square_state_tracker_if.sv
// rtl/square_state_tracker_if.sv - square state tracker control/status bundle
`ifndef SQUARE_STATE_ENCODE_LENGTH
`define SQUARE_STATE_ENCODE_LENGTH 3
`define SQUARE_STRONG     3'd1
`define SQUARE_OKAY       3'd2
`define SQUARE_WEAK       3'd3
`define SQUARE_INVINCIBLE 3'd4
`endif

interface square_state_tracker_if;
  logic                                   FRAME_TICK;
  logic                                   SPAWN;
  logic [`SQUARE_STATE_ENCODE_LENGTH-1:0] SPAWN_STATE;
  logic                                   HIT;
  logic [`SQUARE_STATE_ENCODE_LENGTH-1:0] COLOR;
  logic [11:0]                            RANDOM_RGB;
  logic                                   ALIVE;
  logic                                   DESTROYED;

  modport master (
    output FRAME_TICK, SPAWN, SPAWN_STATE, HIT,
    input  COLOR, RANDOM_RGB, ALIVE, DESTROYED
  );

  modport slave (
    input  FRAME_TICK, SPAWN, SPAWN_STATE, HIT,
    output COLOR, RANDOM_RGB, ALIVE, DESTROYED
  );
endinterface

// File: rtl/square_state_tracker.sv
// rtl/square_state_tracker.sv - per-square durability/invincibility state and random colour source
// Optional feature macro: SQUARE_HIT_COOLDOWN_EN (one accepted hit per frame)
`ifndef SQUARE_STATE_ENCODE_LENGTH
`define SQUARE_STATE_ENCODE_LENGTH 3
`define SQUARE_STRONG     3'd1
`define SQUARE_OKAY       3'd2
`define SQUARE_WEAK       3'd3
`define SQUARE_INVINCIBLE 3'd4
`endif

module square_state_tracker #(
  parameter int unsigned INV_FRAMES = 180,
  parameter int unsigned RGB_FRAMES = 4,
  parameter logic [11:0] LFSR_SEED  = 12'hACE
) (
  input logic                   CLK,
  input logic                   RST,
  square_state_tracker_if.slave bus
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [11:0] SEED_EFF  = (LFSR_SEED == 12'h000) ? 12'h001 : LFSR_SEED;
  localparam logic [11:0] INV_LOAD  = 12'(INV_FRAMES);
  localparam logic [7:0]  DIV_LAST  = 8'(RGB_FRAMES - 1);
  // x^12 + x^6 + x^4 + x + 1 with the x^12 term implied by the shifted-out bit.
  localparam logic [11:0] LFSR_TAPS = 12'h053;

  typedef enum logic [2:0] {
    ST_DEAD,
    ST_STRONG,
    ST_OKAY,
    ST_WEAK,
    ST_INV
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] inv_q, inv_d;
  logic        destroyed_d;
  logic        hit_ok;
  logic        hit_allowed;

  logic [`SQUARE_STATE_ENCODE_LENGTH-1:0] color_q, color_d;
  logic        alive_q;
  logic        destroyed_q;
  logic [7:0]  div_q;
  logic [11:0] lfsr_q;

`ifdef SQUARE_HIT_COOLDOWN_EN
  logic cool_q, cool_d;
  assign hit_allowed = ~cool_q;
`else
  assign hit_allowed = 1'b1;
`endif

  // A hit only counts when no spawn overrides it and the square can still lose durability.
  assign hit_ok = bus.HIT && !bus.SPAWN && hit_allowed &&
                  (state_q == ST_STRONG || state_q == ST_OKAY || state_q == ST_WEAK);

  // Next state: spawn beats hit beats invincibility expiry.
  always_comb begin
    state_d     = state_q;
    inv_d       = inv_q;
    destroyed_d = 1'b0;
    if (bus.SPAWN) begin
      case (bus.SPAWN_STATE)
        `SQUARE_OKAY:       state_d = ST_OKAY;
        `SQUARE_WEAK:       state_d = ST_WEAK;
        `SQUARE_INVINCIBLE: begin
          state_d = ST_INV;
          inv_d   = INV_LOAD;
        end
        default:            state_d = ST_STRONG;
      endcase
    end else if (hit_ok) begin
      case (state_q)
        ST_STRONG: state_d = ST_OKAY;
        ST_OKAY:   state_d = ST_WEAK;
        default: begin
          state_d     = ST_DEAD;
          destroyed_d = 1'b1;
        end
      endcase
    end else if (bus.FRAME_TICK && state_q == ST_INV) begin
      inv_d = inv_q - 12'd1;
      if (inv_q == 12'd1) state_d = ST_STRONG;
    end
  end

  // Selector encoding of the upcoming state; a dead square reports STRONG.
  always_comb begin
    color_d = `SQUARE_STRONG;
    case (state_d)
      ST_OKAY: color_d = `SQUARE_OKAY;
      ST_WEAK: color_d = `SQUARE_WEAK;
      ST_INV:  color_d = `SQUARE_INVINCIBLE;
      default: color_d = `SQUARE_STRONG;
    endcase
  end

  // State, counter and registered status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_DEAD;
      inv_q       <= 12'd0;
      color_q     <= `SQUARE_STRONG;
      alive_q     <= 1'b0;
      destroyed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inv_q       <= inv_d;
      color_q     <= color_d;
      alive_q     <= (state_d != ST_DEAD);
      destroyed_q <= destroyed_d;
    end
  end

`ifdef SQUARE_HIT_COOLDOWN_EN
  // Cooldown arms on an accepted hit and releases on the following frame tick.
  always_comb begin
    cool_d = cool_q;
    if (bus.SPAWN)           cool_d = 1'b0;
    else if (hit_ok)         cool_d = 1'b1;
    else if (bus.FRAME_TICK) cool_d = 1'b0;
  end

  // Cooldown flag register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cool_q <= 1'b0;
    else     cool_q <= cool_d;
  end
`endif

  // Free-running colour LFSR, stepped once every RGB_FRAMES frame ticks.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q  <= 8'd0;
      lfsr_q <= SEED_EFF;
    end else if (bus.FRAME_TICK) begin
      if (div_q == DIV_LAST) begin
        div_q  <= 8'd0;
        lfsr_q <= {lfsr_q[10:0], 1'b0} ^ (lfsr_q[11] ? LFSR_TAPS : 12'h000);
      end else begin
        div_q  <= div_q + 8'd1;
      end
    end
  end

  assign bus.COLOR      = color_q;
  assign bus.ALIVE      = alive_q;
  assign bus.DESTROYED  = destroyed_q;
  assign bus.RANDOM_RGB = lfsr_q;

endmodule

// File: doc/square_state_tracker.md
# square_state_tracker

Per-square state holder feeding the square colour selector in the VGA output path. Tracks a square's durability (strong → okay → weak → destroyed) from ball-hit pulses. Runs a frame-counted invincibility window. Generates the free-running 12-bit pseudo-random colour that the selector displays for invincible squares. Drives the selector's `COLOR` and `RANDOM_RGB` inputs directly, plus liveness/destroy status to game logic.

## Interface
Parameters:
- `INV_FRAMES`, 180: invincibility duration in frames (3 s at 60 Hz); legal 1..4095.
- `RGB_FRAMES`, 4: frames between random-colour updates; legal 1..255.
- `LFSR_SEED`, 12'hACE: LFSR reset value; a seed of 0 is replaced by 12'h001.

Ports:
- `CLK` in 1: system clock.
- `RST` in 1: one clock; reset is asynchronous and active-high.
- `FRAME_TICK` in 1: one-cycle pulse per VGA frame (end of visible area).
- `SPAWN` in 1: one-cycle pulse; (re)load square with `SPAWN_STATE`.
- `SPAWN_STATE` in `SQUARE_STATE_ENCODE_LENGTH`: initial state; one of the `SQUARE_*` encodings from Head.v.
- `HIT` in 1: one-cycle pulse; ball struck this square.
- `COLOR` out `SQUARE_STATE_ENCODE_LENGTH`: current state encoding to selector.
- `RANDOM_RGB` out 12: pseudo-random colour to selector.
- `ALIVE` out 1: square present and must be drawn/collided.
- `DESTROYED` out 1: one-cycle pulse when the square is destroyed.

## Operation
- FSM states: DEAD, STRONG, OKAY, WEAK, INVINCIBLE. `COLOR` = matching `SQUARE_*` macro; in DEAD, `COLOR` = `SQUARE_STRONG` and `ALIVE` = 0.
- `SPAWN` (any state) → state from `SPAWN_STATE`. An undefined encoding → STRONG. Spawning INVINCIBLE loads the invincibility counter with `INV_FRAMES`.
- `HIT` transitions: STRONG→OKAY, OKAY→WEAK, WEAK→DEAD with `DESTROYED` pulse; ignored in INVINCIBLE and DEAD.
- Priority: `RST` > `SPAWN` > `HIT` > invincibility expiry. `SPAWN` and `HIT` in the same cycle: spawn wins and the hit is dropped.
- Invincibility counter, 12 bits: decrements on each `FRAME_TICK` while INVINCIBLE. When it reaches 0 on a tick → STRONG. A `HIT` coinciding with expiry is ignored.
- Random colour: 12-bit Galois LFSR, polynomial x^12+x^6+x^4+x+1.
  - 8-bit frame divider counts `FRAME_TICK`s. LFSR advances one step when the divider reaches `RGB_FRAMES`-1, then the divider clears.
  - Free-running in all states; never reaches all-zero.
  - `RANDOM_RGB` = LFSR register.

## Timing
- All outputs registered.
- Reset values:
  - state DEAD; `COLOR` = `SQUARE_STRONG`; `ALIVE` = 0; `DESTROYED` = 0.
  - LFSR = `LFSR_SEED` (or 1); `RANDOM_RGB` = same; counters = 0.
- `HIT`/`SPAWN` at edge N → `COLOR`/`ALIVE` updated after edge N; `DESTROYED` high for exactly the cycle following edge N.
- Expiry: `COLOR` changes after the edge sampling the `INV_FRAMES`-th `FRAME_TICK` since spawn.
- `RANDOM_RGB` changes after the edge sampling the qualifying `FRAME_TICK`; stable for `RGB_FRAMES` frames otherwise.
- `RST` mid-invincibility or mid-hit sequence returns every output to its reset value immediately (asynchronously); no `DESTROYED` pulse.

## Configuration
- `SQUARE_HIT_COOLDOWN_EN` defined: after an accepted `HIT`, further `HIT`s are ignored until after the next `FRAME_TICK`. A `HIT` in the same cycle as that tick is still ignored. `SPAWN` clears the cooldown.
- Undefined: every `HIT` pulse is evaluated independently; back-to-back hits on consecutive cycles degrade STRONG→OKAY→WEAK.

## Test plan
- Reset, then `SPAWN` with `SQUARE_STRONG`; 3 `HIT`s spaced by `FRAME_TICK` → `COLOR` OKAY, then WEAK; then `ALIVE`=0, with `DESTROYED` high for exactly 1 cycle.
- `SPAWN` INVINCIBLE with `INV_FRAMES`=3; `HIT` each frame → `COLOR` stays `SQUARE_INVINCIBLE` through the 2nd tick; becomes STRONG after the 3rd tick; no `DESTROYED`.
- `SPAWN` and `HIT` asserted in the same cycle with `SPAWN_STATE`=WEAK → `COLOR`=WEAK, `ALIVE`=1, `DESTROYED`=0.
- `RGB_FRAMES`=2, seed 12'hACE; 4 `FRAME_TICK`s → `RANDOM_RGB` changes only on ticks 2 and 4, matching a reference LFSR model. Seed 0 → reset value 12'h001.
- Two `HIT`s on consecutive cycles from STRONG → OKAY with macro defined; WEAK without.
- `RST` pulsed while INVINCIBLE with counter mid-count → `ALIVE`=0 and `RANDOM_RGB`=seed immediately; the following `SPAWN` restarts the counter at `INV_FRAMES`.
